ifetch_ctrl: RTL and testbench

Instruction-fetch controller for the pipelined MIPS core. It owns the program counter and drives the word address into the combinational instruction ROM. It captures the returned word into the IF/ID pipeline register, and applies hazard stalls, branch/jump redirects, halt-on-syscall and out-of-range fetch faults. It sits between the hazard/branch logic and the ID stage.

---
 rtl/ifetch_ctrl_pkg.sv | 20 ++
 rtl/ifid_reg.sv | 54 +++++
 rtl/ifetch_ctrl.sv | 114 +++++++++++
 tb/tb_ifetch_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_ctrl_pkg
// Shared definitions for the MIPS fetch path: default datapath widths so the
// ROM, ID stage and fetch controller agree, the syscall word that halts
// fetch, and the fetch-controller state encodings.
// Ports: none (package).
// ---------------------------------------------------------------------------
package ifetch_ctrl_pkg;

    localparam int unsigned DEF_PC_SIZE    = 11;
    localparam int unsigned DEF_INSTR_SIZE = 32;

    // syscall: fetch stops after this word enters IF/ID
    localparam logic [31:0] HALT_INSTR = 32'h0000_000C;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

endpackage

// File: rtl/ifid_reg.sv
// ---------------------------------------------------------------------------
// ifid_reg
// Pipeline stage register (IF/ID) with load / hold / squash controls.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears all)
//   i_load            capture {valid=1, pc, pc+1, instr}
//   i_squash          clear valid only; other fields hold (wins over load)
//   i_pc, i_instr     incoming PC and instruction word
//   o_valid, o_pc, o_pc_plus1, o_instr   registered stage contents
// Neither control asserted: everything holds.
// ---------------------------------------------------------------------------
module ifid_reg #(
    parameter int unsigned PC_SIZE    = 11,
    parameter int unsigned INSTR_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_squash,
    input  logic [PC_SIZE-1:0]    i_pc,
    input  logic [INSTR_SIZE-1:0] i_instr,
    output logic                  o_valid,
    output logic [PC_SIZE-1:0]    o_pc,
    output logic [PC_SIZE-1:0]    o_pc_plus1,
    output logic [INSTR_SIZE-1:0] o_instr
);

    logic                  r_valid;
    logic [PC_SIZE-1:0]    r_pc;
    logic [PC_SIZE-1:0]    r_pc_plus1;
    logic [INSTR_SIZE-1:0] r_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_pc_plus1 <= '0;
            r_instr    <= '0;
        end else if (i_squash) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_pc       <= i_pc;
            r_pc_plus1 <= i_pc + PC_SIZE'(1);   // wraps, no carry out
            r_instr    <= i_instr;
        end
    end

    assign o_valid    = r_valid;
    assign o_pc       = r_pc;
    assign o_pc_plus1 = r_pc_plus1;
    assign o_instr    = r_instr;

endmodule

// File: rtl/ifetch_ctrl.sv
// ---------------------------------------------------------------------------
// ifetch_ctrl
// Instruction-fetch controller: owns the PC, addresses the combinational
// instruction ROM, fills IF/ID, and handles stalls, redirects, halt on
// syscall and out-of-range fetch faults.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   stall                         hazard hold: PC and IF/ID freeze
//   redirect_valid, redirect_pc   taken branch/jump target (word index)
//   im_pc, im_instr               ROM address (current PC) / same-cycle data
//   ifid_valid, ifid_pc, ifid_pc_plus1, ifid_instr   IF/ID stage contents
//   halted, fault                 registered state decodes
// Per-cycle priority: rst > redirect > FAULT > stall > HALT > fetch.
// ---------------------------------------------------------------------------
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_SIZE      = DEF_PC_SIZE,
    parameter int unsigned INSTR_SIZE   = DEF_INSTR_SIZE,
    parameter int unsigned ROM_CAPACITY = 256,
    parameter int unsigned RESET_PC     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [PC_SIZE-1:0]    redirect_pc,
    output logic [PC_SIZE-1:0]    im_pc,
    input  logic [INSTR_SIZE-1:0] im_instr,
    output logic                  ifid_valid,
    output logic [PC_SIZE-1:0]    ifid_pc,
    output logic [PC_SIZE-1:0]    ifid_pc_plus1,
    output logic [INSTR_SIZE-1:0] ifid_instr,
    output logic                  halted,
    output logic                  fault
);

    logic [PC_SIZE-1:0] r_pc;
    logic [1:0]         r_state;

    logic [PC_SIZE-1:0] w_pc_next;
    logic [1:0]         w_state_next;
    logic               w_load;
    logic               w_squash;
    logic               w_redirect;
    logic               w_pc_oob;
    logic               w_is_halt;

    // A faulted controller ignores redirects; only rst recovers it.
    assign w_redirect = redirect_valid && (r_state != ST_FAULT);
    assign w_pc_oob   = (32'(r_pc) >= ROM_CAPACITY);
    assign w_is_halt  = (im_instr == INSTR_SIZE'(HALT_INSTR));

    always_comb begin
        w_pc_next    = r_pc;
        w_state_next = r_state;
        w_load       = 1'b0;
        w_squash     = 1'b0;
        if (w_redirect) begin
            // squash the wrong-path word; this also cancels a speculative halt
            w_pc_next    = redirect_pc;
            w_squash     = 1'b1;
            w_state_next = ST_RUN;
        end else if (r_state == ST_FAULT) begin
            // IF/ID valid was already cleared on the edge that entered FAULT
        end else if (stall) begin
            // zero-cycle response: nothing updates
        end else if (r_state == ST_HALT) begin
            w_squash = 1'b1;
        end else if (w_pc_oob) begin
            // out-of-range check outranks halt detect on the same word
            w_squash     = 1'b1;
            w_state_next = ST_FAULT;
        end else begin
            w_load = 1'b1;
            if (w_is_halt) begin
                w_state_next = ST_HALT;   // PC parks on the syscall
            end else begin
                w_pc_next = r_pc + PC_SIZE'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= PC_SIZE'(RESET_PC);
            r_state <= ST_RUN;
        end else begin
            r_pc    <= w_pc_next;
            r_state <= w_state_next;
        end
    end

    ifid_reg #(
        .PC_SIZE    (PC_SIZE),
        .INSTR_SIZE (INSTR_SIZE)
    ) u_ifid_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_squash   (w_squash),
        .i_pc       (r_pc),
        .i_instr    (im_instr),
        .o_valid    (ifid_valid),
        .o_pc       (ifid_pc),
        .o_pc_plus1 (ifid_pc_plus1),
        .o_instr    (ifid_instr)
    );

    assign im_pc  = r_pc;
    assign halted = (r_state == ST_HALT);
    assign fault  = (r_state == ST_FAULT);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ifetch_ctrl
// Scoreboard bench. The driver applies inputs on the falling edge, advances a
// behavioural model of the fetch unit and queues the expected post-edge
// outputs; a monitor samples 1 ns after each rising edge and compares.
// Main DUT: PC_SIZE=11, ROM_CAPACITY=256. Second DUT: PC_SIZE=4,
// ROM_CAPACITY=16, RESET_PC=14, free-running to exercise PC wrap.
// ---------------------------------------------------------------------------
module tb_ifetch_ctrl;

    localparam logic [31:0] SYSCALL = 32'h0000_000C;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT
    logic        rst, stall, redirect_valid;
    logic [10:0] redirect_pc, im_pc, ifid_pc, ifid_pc_plus1;
    logic [31:0] im_instr, ifid_instr;
    logic        ifid_valid, halted, fault;

    // wrap DUT
    logic        rst2;
    logic        stall2 = 1'b0;
    logic        redirect_valid2 = 1'b0;
    logic [3:0]  redirect_pc2 = 4'd0;
    logic [3:0]  im_pc2, ifid_pc2, ifid_pc_plus12;
    logic [31:0] im_instr2, ifid_instr2;
    logic        ifid_valid2, halted2, fault2;

    logic [31:0] rom [0:2047];

    assign im_instr  = rom[im_pc];
    assign im_instr2 = {28'h1000_000, im_pc2};

    ifetch_ctrl #(
        .PC_SIZE      (11),
        .INSTR_SIZE   (32),
        .ROM_CAPACITY (256),
        .RESET_PC     (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .im_pc          (im_pc),
        .im_instr       (im_instr),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus1  (ifid_pc_plus1),
        .ifid_instr     (ifid_instr),
        .halted         (halted),
        .fault          (fault)
    );

    ifetch_ctrl #(
        .PC_SIZE      (4),
        .INSTR_SIZE   (32),
        .ROM_CAPACITY (16),
        .RESET_PC     (14)
    ) dut_wrap (
        .clk            (clk),
        .rst            (rst2),
        .stall          (stall2),
        .redirect_valid (redirect_valid2),
        .redirect_pc    (redirect_pc2),
        .im_pc          (im_pc2),
        .im_instr       (im_instr2),
        .ifid_valid     (ifid_valid2),
        .ifid_pc        (ifid_pc2),
        .ifid_pc_plus1  (ifid_pc_plus12),
        .ifid_instr     (ifid_instr2),
        .halted         (halted2),
        .fault          (fault2)
    );

    typedef struct {
        logic [10:0] im_pc;
        logic        v;
        logic [10:0] ipc;
        logic [10:0] ip1;
        logic [31:0] ins;
        logic        h;
        logic        f;
        logic [3:0]  im2;
        logic        v2;
        logic [3:0]  ipc2;
        logic [3:0]  ip12;
        logic [31:0] ins2;
    } exp_t;

    exp_t q[$];

    typedef enum {Running, Halted, Faulted} mode_e;

    // reference model of the main DUT
    int          mpc;
    mode_e       mmode;
    bit          mv;
    int          mipc, mip1;
    logic [31:0] mins;
    // reference model of the wrap DUT
    int          m2pc;
    bit          m2v;
    int          m2ipc, m2ip1;
    logic [31:0] m2ins;

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;

    task automatic cyc(input bit r, input bit s, input bit rv, input int rpc);
        exp_t e;
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = 11'(rpc);
        rst2           = (cyc_n < 2);

        if (r) begin
            mpc = 0; mmode = Running; mv = 0; mipc = 0; mip1 = 0; mins = '0;
        end else if (rv && mmode != Faulted) begin
            mpc = rpc; mv = 0; mmode = Running;
        end else if (mmode == Faulted || s) begin
            // nothing moves
        end else if (mmode == Halted) begin
            mv = 0;
        end else if (mpc >= 256) begin
            mv = 0; mmode = Faulted;
        end else begin
            mv = 1; mipc = mpc; mip1 = (mpc + 1) % 2048; mins = rom[mpc];
            if (rom[mpc] == SYSCALL) mmode = Halted;
            else mpc = (mpc + 1) % 2048;
        end

        if (rst2) begin
            m2pc = 14; m2v = 0; m2ipc = 0; m2ip1 = 0; m2ins = '0;
        end else begin
            m2v = 1; m2ipc = m2pc; m2ip1 = (m2pc + 1) % 16;
            m2ins = 32'h1000_0000 + m2pc;
            m2pc = (m2pc + 1) % 16;
        end

        e.im_pc = 11'(mpc);  e.v = mv;  e.ipc = 11'(mipc);  e.ip1 = 11'(mip1);
        e.ins = mins;  e.h = (mmode == Halted);  e.f = (mmode == Faulted);
        e.im2 = 4'(m2pc);  e.v2 = m2v;  e.ipc2 = 4'(m2ipc);  e.ip12 = 4'(m2ip1);
        e.ins2 = m2ins;
        q.push_back(e);
        cyc_n++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic free_run(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 0);
    endtask

    // monitor
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if ({im_pc, ifid_valid, ifid_pc, ifid_pc_plus1, ifid_instr, halted, fault}
                !== {e.im_pc, e.v, e.ipc, e.ip1, e.ins, e.h, e.f}) begin
                fails++;
                $display("FAIL main edge: got im_pc=%0d v=%0b pc=%0d pc1=%0d ins=%h h=%0b f=%0b, expected im_pc=%0d v=%0b pc=%0d pc1=%0d ins=%h h=%0b f=%0b (t=%0t)",
                         im_pc, ifid_valid, ifid_pc, ifid_pc_plus1, ifid_instr, halted, fault,
                         e.im_pc, e.v, e.ipc, e.ip1, e.ins, e.h, e.f, $time);
            end
            tests++;
            if ({im_pc2, ifid_valid2, ifid_pc2, ifid_pc_plus12, ifid_instr2, halted2, fault2}
                !== {e.im2, e.v2, e.ipc2, e.ip12, e.ins2, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL wrap edge: got im_pc=%0d v=%0b pc=%0d pc1=%0d ins=%h h=%0b f=%0b, expected im_pc=%0d v=%0b pc=%0d pc1=%0d ins=%h h=0 f=0 (t=%0t)",
                         im_pc2, ifid_valid2, ifid_pc2, ifid_pc_plus12, ifid_instr2, halted2,
                         fault2, e.im2, e.v2, e.ipc2, e.ip12, e.ins2, $time);
            end
        end
    end

    initial begin
        for (int k = 0; k < 2048; k++) rom[k] = 32'h1000_0000 + k;
        rom[10] = SYSCALL;

        // sequential fetch after a 2-cycle reset
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0);
        free_run(5);
        // stall at pc=5
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 0);
        free_run(2);
        // redirect overriding stall at pc=7
        cyc(1'b0, 1'b1, 1'b1, 40);
        free_run(2);
        // halt on ROM[10], then cancel with a redirect
        cyc(1'b0, 1'b0, 1'b1, 8);
        free_run(5);
        cyc(1'b0, 1'b0, 1'b1, 3);
        free_run(3);
        // halt held under stall
        cyc(1'b0, 1'b0, 1'b1, 9);
        free_run(2);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 0);
        free_run(1);
        cyc(1'b0, 1'b0, 1'b1, 0);
        free_run(1);
        // fault via out-of-range redirect; redirect ignored; rst clears
        cyc(1'b0, 1'b0, 1'b1, 300);
        free_run(1);
        cyc(1'b0, 1'b0, 1'b1, 0);
        free_run(2);
        cyc(1'b1, 1'b0, 1'b0, 0);
        free_run(2);
        // sequential walk off the end of the ROM
        cyc(1'b0, 1'b0, 1'b1, 253);
        free_run(5);
        cyc(1'b1, 1'b1, 1'b0, 0);
        free_run(1);

        // randomized phase with sprinkled syscalls
        for (int k = 0; k < 2048; k++)
            rom[k] = ($urandom_range(0, 15) == 0) ? SYSCALL : $urandom();
        for (int i = 0; i < 3000; i++) begin
            bit r, s, rv;
            int t;
            r  = ($urandom_range(0, 59) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 7) == 0);
            t  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(240, 300))
                                               : int'($urandom_range(0, 255));
            cyc(r, s, rv, t);
        end

        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending entries, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
